// File: rtl/sisc_pkg.sv
// sisc_pkg: definitions shared by the data-memory responder and its storage.
//   state_t : responder FSM states (IDLE, WAIT, ACK)
//   DATA_W  : data word width (32)
//   ADDR_W  : word address width (16)
package sisc_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with a synchronous write and a combinational read.
// One shared address serves both the read and the write.
// Contents are not reset.
//   clk   : write clock (rising edge)
//   we    : write enable
//   addr  : word index, always < DEPTH
//   wdata : write data
//   rdata : data at addr, combinational
module dmem_array
  import sisc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder with wait states.
// In IDLE, a request captures addr, we and wdata. The FSM then spends WAIT_CYC
// cycles in WAIT and one cycle in ACK.
// In the ACK cycle, ack pulses and a write commits on the closing edge.
// Dropping req while in WAIT aborts the access.
// Build option DMEM_RANGE_ERR_EN adds the err output.
//   With it, an access at addr >= DEPTH writes nothing, returns 0 and raises err
//   with ack.
//   Without it, the address wraps modulo DEPTH.
// Ports:
//   clk, rst_f        : clock and async active-high reset
//   req, we, addr,
//   wdata             : core request; req is held until ack
//   ack, rdata        : one-cycle completion; rdata is nonzero only during ack
//   busy              : high whenever the FSM is not IDLE
//   err               : (DMEM_RANGE_ERR_EN only) out-of-range flag, with ack
module dmem_resp
  import sisc_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
`ifdef DMEM_RANGE_ERR_EN
  output logic              err,
`endif
  output logic              busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      CNT_INIT = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata;
  logic              capture;
  logic [ADDR_W:0]   idx_full;
  logic              in_range;
  logic              wr_en;
  logic [DATA_W-1:0] arr_rdata;

  assign capture = (state == IDLE) && req;

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        cap_addr  <= addr;
        cap_we    <= we;
        cap_wdata <= wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req) begin
        if (WAIT_CYC == 0) state_nx = ACK;
        else begin
          state_nx = WAIT;
          cnt_nx   = CNT_INIT;
        end
      end
      // req is rechecked every cycle so the core can withdraw an access.
      WAIT: begin
        if (!req)           state_nx = IDLE;
        else if (cnt == '0) state_nx = ACK;
        else                cnt_nx   = cnt - 4'd1;
      end
      // ACK always returns to IDLE; a request held high is only taken from IDLE.
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The modulo leaves in-range addresses unchanged and wraps out-of-range
  // addresses when range checking is disabled.
  assign idx_full = {1'b0, cap_addr} % DEPTH_V;

`ifdef DMEM_RANGE_ERR_EN
  assign in_range = ({1'b0, cap_addr} < DEPTH_V);
  assign err      = ack && !in_range;
`else
  assign in_range = 1'b1;
`endif

  assign ack   = (state == ACK);
  assign busy  = (state != IDLE);
  assign wr_en = ack && cap_we && in_range;
  assign rdata = (ack && in_range) ? arr_rdata : '0;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .addr  (idx_full[AW-1:0]),
    .wdata (cap_wdata),
    .rdata (arr_rdata)
  );
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp. Two instances share clk, rst_f, we, addr and
// wdata but have separate req lines:
//   u_a : WAIT_CYC=2 (main scenarios)
//   u_b : WAIT_CYC=0 (zero-wait latency)
// Latency is counted in cycles after the req-sampling edge. ack is expected in
// cycle WAIT_CYC+1.
module tb_dmem_resp;
  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ack_a, ack_b, busy_a, busy_b;
  logic [31:0] rdata_a, rdata_b;
`ifdef DMEM_RANGE_ERR_EN
  logic        err_a, err_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH(256), .WAIT_CYC(2)) u_a (
    .clk(clk), .rst_f(rst_f), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_a), .rdata(rdata_a),
`ifdef DMEM_RANGE_ERR_EN
    .err(err_a),
`endif
    .busy(busy_a));

  dmem_resp #(.DEPTH(256), .WAIT_CYC(0)) u_b (
    .clk(clk), .rst_f(rst_f), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_b), .rdata(rdata_b),
`ifdef DMEM_RANGE_ERR_EN
    .err(err_b),
`endif
    .busy(busy_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one access on instance a (sel=0) or b (sel=1).
  // Outputs:
  //   ack_cyc : cycle (after the sampling edge) in which ack was seen; -1 if none
  //   rd, er  : rdata and err captured in that cycle
  //   busy_n  : number of busy cycles up to and including ack
  task automatic access(input bit sel, input bit w, input logic [15:0] a,
                        input logic [31:0] d, output int ack_cyc,
                        output logic [31:0] rd, output logic er,
                        output int busy_n);
    we = w; addr = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    ack_cyc = -1; rd = '0; er = 1'b0; busy_n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sel ? busy_b : busy_a) busy_n++;
      if (sel ? ack_b : ack_a) begin
        ack_cyc = i;
        rd = sel ? rdata_b : rdata_a;
`ifdef DMEM_RANGE_ERR_EN
        er = sel ? err_b : err_a;
`endif
        break;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_f = 1'b1;
    #1;
    checks++;
    if (ack_a !== 1'b0 || busy_a !== 1'b0 || rdata_a !== 32'h0) begin
      failures++;
      $display("FAIL reset_a ack=%b busy=%b rdata=%h required 0/0/0", ack_a, busy_a, rdata_a);
    end
    checks++;
    if (ack_b !== 1'b0 || busy_b !== 1'b0 || rdata_b !== 32'h0) begin
      failures++;
      $display("FAIL reset_b ack=%b busy=%b rdata=%h required 0/0/0", ack_b, busy_b, rdata_b);
    end
`ifdef DMEM_RANGE_ERR_EN
    checks++;
    if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err err=%b required 0", err_a); end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_f = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait;
    int c, b; logic [31:0] rd; logic er;
    access(1'b1, 1'b0, 16'd0, 32'h0, c, rd, er, b);
    checks++;
    if (c !== 1) begin failures++; $display("FAIL zw_ack_cyc got=%0d required 1", c); end
    checks++;
    if (busy_b !== 1'b0) begin failures++; $display("FAIL zw_busy_after got=%b required 0", busy_b); end
  endtask

  task automatic test_write_read;
    int c, b; logic [31:0] rd; logic er;
    access(1'b0, 1'b1, 16'd5, 32'hDEADBEEF, c, rd, er, b);
    checks++;
    if (c !== 3) begin failures++; $display("FAIL wr_ack_cyc got=%0d required 3", c); end
    checks++;
    if (b !== 3) begin failures++; $display("FAIL wr_busy_cycles got=%0d required 3", b); end
    checks++;
    if (busy_a !== 1'b0 || ack_a !== 1'b0 || rdata_a !== 32'h0) begin
      failures++;
      $display("FAIL wr_idle busy=%b ack=%b rdata=%h required 0/0/0", busy_a, ack_a, rdata_a);
    end
    access(1'b0, 1'b0, 16'd5, 32'h0, c, rd, er, b);
    checks++;
    if (c !== 3) begin failures++; $display("FAIL rd_ack_cyc got=%0d required 3", c); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h required deadbeef", rd); end
`ifdef DMEM_RANGE_ERR_EN
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL rd_err_inrange got=%b required 0", er); end
`endif
  endtask

  task automatic test_abort;
    int c, b; logic [31:0] rd; logic er; bit saw_ack;
    access(1'b0, 1'b1, 16'd9, 32'h11111111, c, rd, er, b);
    we = 1'b1; addr = 16'd9; wdata = 32'h12345678; req_a = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL ab_busy_wait got=%b required 1", busy_a); end
    req_a = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b0 || ack_a !== 1'b0) begin
      failures++;
      $display("FAIL ab_fall busy=%b ack=%b required 0/0", busy_a, ack_a);
    end
    saw_ack = 1'b0;
    repeat (4) begin tick(); if (ack_a) saw_ack = 1'b1; end
    checks++;
    if (saw_ack) begin failures++; $display("FAIL ab_no_ack got=1 required 0"); end
    access(1'b0, 1'b0, 16'd9, 32'h0, c, rd, er, b);
    checks++;
    if (rd !== 32'h11111111) begin failures++; $display("FAIL ab_mem got=%h required 11111111", rd); end
  endtask

  task automatic test_reset_mid;
    int c, b; logic [31:0] rd; logic er;
    access(1'b0, 1'b1, 16'd3, 32'h33333333, c, rd, er, b);
    we = 1'b1; addr = 16'd3; wdata = 32'hBADBAD00; req_a = 1'b1;
    tick();
    tick();
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL rm_busy_pre got=%b required 1", busy_a); end
    #2 rst_f = 1'b1;
    #1;
    checks++;
    if (busy_a !== 1'b0 || ack_a !== 1'b0) begin
      failures++;
      $display("FAIL rm_async busy=%b ack=%b required 0/0", busy_a, ack_a);
    end
    req_a = 1'b0;
    @(negedge clk);
    rst_f = 1'b0;
    tick();
    access(1'b0, 1'b0, 16'd3, 32'h0, c, rd, er, b);
    checks++;
    if (c !== 3 || rd !== 32'h33333333) begin
      failures++;
      $display("FAIL rm_after ack_cyc=%0d rdata=%h required 3/33333333", c, rd);
    end
  endtask

  task automatic test_capture;
    int c, b; logic [31:0] rd; logic er;
    access(1'b0, 1'b1, 16'd8, 32'h08080808, c, rd, er, b);
    we = 1'b1; addr = 16'd7; wdata = 32'h77777777; req_a = 1'b1;
    tick();
    we = 1'b0; addr = 16'd8; wdata = 32'h88888888;
    tick();
    tick();
    checks++;
    if (ack_a !== 1'b1) begin failures++; $display("FAIL cap_ack got=%b required 1", ack_a); end
    req_a = 1'b0;
    tick();
    access(1'b0, 1'b0, 16'd7, 32'h0, c, rd, er, b);
    checks++;
    if (rd !== 32'h77777777) begin failures++; $display("FAIL cap_addr7 got=%h required 77777777", rd); end
    access(1'b0, 1'b0, 16'd8, 32'h0, c, rd, er, b);
    checks++;
    if (rd !== 32'h08080808) begin failures++; $display("FAIL cap_addr8 got=%h required 08080808", rd); end
  endtask

  task automatic test_back_to_back;
    int c, b, gap; logic [31:0] rd; logic er;
    we = 1'b1; addr = 16'd20; wdata = 32'h20202020; req_a = 1'b1;
    c = -1;
    for (int i = 1; i <= 20; i++) begin tick(); if (ack_a) begin c = i; break; end end
    checks++;
    if (c !== 3) begin failures++; $display("FAIL b2b_first got=%0d required 3", c); end
    // req stays high through ACK; the second access starts from IDLE.
    addr = 16'd21; wdata = 32'h21212121;
    gap = -1;
    for (int i = 1; i <= 20; i++) begin tick(); if (ack_a) begin gap = i; break; end end
    checks++;
    if (gap !== 4) begin failures++; $display("FAIL b2b_spacing got=%0d required 4", gap); end
    req_a = 1'b0;
    tick();
    access(1'b0, 1'b0, 16'd20, 32'h0, c, rd, er, b);
    checks++;
    if (rd !== 32'h20202020) begin failures++; $display("FAIL b2b_mem20 got=%h required 20202020", rd); end
    access(1'b0, 1'b0, 16'd21, 32'h0, c, rd, er, b);
    checks++;
    if (rd !== 32'h21212121) begin failures++; $display("FAIL b2b_mem21 got=%h required 21212121", rd); end
  endtask

  task automatic test_range;
    int c, b; logic [31:0] rd; logic er;
    access(1'b0, 1'b1, 16'h0105, 32'hA5A5A5A5, c, rd, er, b);
    checks++;
    if (c !== 3) begin failures++; $display("FAIL rng_ack_cyc got=%0d required 3", c); end
`ifdef DMEM_RANGE_ERR_EN
    checks++;
    if (er !== 1'b1) begin failures++; $display("FAIL rng_err_wr got=%b required 1", er); end
    access(1'b0, 1'b0, 16'h0105, 32'h0, c, rd, er, b);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL rng_rd_oor err=%b rdata=%h required 1/00000000", er, rd);
    end
    access(1'b0, 1'b0, 16'd5, 32'h0, c, rd, er, b);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rng_addr5 got=%h required deadbeef", rd); end
`else
    access(1'b0, 1'b0, 16'd5, 32'h0, c, rd, er, b);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL rng_wrap got=%h required a5a5a5a5", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_write_read();
    test_abort();
    test_reset_mid();
    test_capture();
    test_back_to_back();
    test_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit data words stored.
REQ-002 SHALL have parameter WAIT_CYC, default 2: wait-state cycles inserted before each acknowledge (legal range 0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_f, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, 1: core access request, held high until ack.
REQ-007 SHALL have port we, input, 1: 1 = write, 0 = read; qualified by req.
REQ-008 SHALL have port addr, input, 16: word address.
REQ-009 SHALL have port wdata, input, 32: write data.
REQ-010 SHALL have port ack, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32: read data, valid only while ack=1.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-014 SHALL, in IDLE with req=1, capture addr/we/wdata and go to WAIT (WAIT_CYC>0) or ACK (WAIT_CYC=0).
REQ-015 SHALL, in WAIT, load a 4-bit counter with WAIT_CYC-1 on entry and go to ACK when the counter reaches 0.
REQ-016 SHALL assert ack for exactly one cycle in ACK, i.e. WAIT_CYC+1 cycles after the req-sampling edge, then return to IDLE.
REQ-017 SHALL commit a write to storage on the ACK-state edge only, using the captured address and data.
REQ-018 SHALL drive rdata with the word at the captured address during ACK and 0 otherwise.
REQ-019 SHALL, if req drops in WAIT, abort to IDLE next cycle with no write and no ack.
REQ-020 SHALL not accept a new request in the ACK cycle; back-to-back requests start from IDLE, so minimum spacing is WAIT_CYC+2 cycles.
REQ-021 SHALL ignore changes to addr/we/wdata after capture.
REQ-022 SHALL handle an access with addr >= DEPTH as defined in Configuration.

Reset
REQ-023 SHALL, on rst_f=1, force IDLE, ack=0, busy=0, rdata=0, counter=0, err=0 immediately.
REQ-024 SHALL not clear storage contents on reset.
REQ-025 SHALL abandon an in-flight access on reset, with no write committed.

Configuration
REQ-026 SHALL, with DMEM_RANGE_ERR_EN defined, add output err (1 bit), asserted with ack for any access with addr >= DEPTH; that access writes nothing and returns rdata=0.
REQ-027 SHALL, without DMEM_RANGE_ERR_EN, have no err port and wrap addr modulo DEPTH.

Structure
REQ-028 SHALL import the state enum, the 32-bit data width and the 16-bit address width from shared package sisc_pkg.
REQ-029 SHALL place storage in sub-module dmem_array: synchronous write, combinational read.

Verification
REQ-030 Bench: WAIT_CYC=2; write 0xDEADBEEF to addr 5 -> ack on the 3rd edge after req is sampled, busy high for 3 cycles; a read of addr 5 then returns 0xDEADBEEF with ack.
REQ-031 Bench: WAIT_CYC=0; read addr 0 after reset -> ack on the 1st edge after req is sampled.
REQ-032 Bench: req dropped in the 1st WAIT cycle of a write of 0x12345678 to addr 9 -> no ack, busy falls next cycle, addr 9 unchanged.
REQ-033 Bench: rst_f pulsed mid-WAIT of a write to addr 3 -> ack/busy go to 0 at once, addr 3 unchanged, next request completes normally.
REQ-034 Bench: DEPTH=256, write 0xA5A5A5A5 to addr 0x0105 -> with DMEM_RANGE_ERR_EN: err=1, ack=1, addr 5 unchanged; without it: addr 5 reads 0xA5A5A5A5.
REQ-035 Bench: change addr and wdata during WAIT -> originally captured values are used.
